// File: rtl/regfile_pkg.sv
// Shared constants and read-FSM state encoding for the register-file access controller.
// No logic; imported by the controller top and its writeback FIFO.
package regfile_pkg;
    localparam int RF_AW       = 4;
    localparam int RF_DW       = 32;
    localparam int RF_NUM_REGS = 16;
    localparam int RF_WB_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        HOLD  = 2'd3
    } rd_state_e;
endpackage

// File: rtl/regfile_access_ctrl_wb_fifo.sv
// Writeback FIFO: pops its head every cycle it is non-empty; push accepted unless full and not popping.
// Exposes a newest-first forwarding lookup over entries that survive this cycle's pop plus the incoming push.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH  = RF_WB_DEPTH,
    parameter int DATA_W = RF_DW,
    parameter int ADDR_W = RF_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push_vld,
    input  logic [ADDR_W-1:0] i_push_dst,
    input  logic [DATA_W-1:0] i_push_dat,
    output logic              o_push_rdy,
    output logic              o_pop_vld,
    output logic [ADDR_W-1:0] o_pop_dst,
    output logic [DATA_W-1:0] o_pop_dat,
    output logic              o_empty,
    input  logic [ADDR_W-1:0] i_cmp_a,
    input  logic [ADDR_W-1:0] i_cmp_b,
    output logic              o_hit_a,
    output logic              o_hit_b,
    output logic [DATA_W-1:0] o_fwd_a,
    output logic [DATA_W-1:0] o_fwd_b
);
    localparam int PW = $clog2(DEPTH);

    logic [ADDR_W-1:0] r_dst [DEPTH];
    logic [DATA_W-1:0] r_dat [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW:0]       r_count;

    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic [DEPTH-1:1]  w_match_a;
    logic [DEPTH-1:1]  w_match_b;

    assign o_empty    = (r_count == '0);
    assign w_full     = (r_count == (PW+1)'(DEPTH));
    assign w_pop      = !o_empty;
    assign o_push_rdy = !w_full || w_pop;
    assign w_push     = i_push_vld && o_push_rdy;
    assign o_pop_vld  = w_pop;
    assign o_pop_dst  = w_pop ? r_dst[r_rd_ptr] : '0;
    assign o_pop_dat  = w_pop ? r_dat[r_rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_dst[i] <= '0;
                r_dat[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_dst[r_wr_ptr] <= i_push_dst;
                r_dat[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
        end
    end

    // Match vector indexed by age; age 0 is the head, which is always popped this cycle.
    always_comb begin
        w_match_a = '0;
        w_match_b = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if ((PW+1)'(i) < r_count) begin
                w_match_a[i] = (r_dst[r_rd_ptr + PW'(i)] == i_cmp_a);
                w_match_b[i] = (r_dst[r_rd_ptr + PW'(i)] == i_cmp_b);
            end
        end
    end

    always_comb begin
        o_hit_a = 1'b0;
        o_hit_b = 1'b0;
        o_fwd_a = '0;
        o_fwd_b = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (w_match_a[i]) begin
                o_hit_a = 1'b1;
                o_fwd_a = r_dat[r_rd_ptr + PW'(i)];
            end
            if (w_match_b[i]) begin
                o_hit_b = 1'b1;
                o_fwd_b = r_dat[r_rd_ptr + PW'(i)];
            end
        end
        if (w_push && (i_push_dst == i_cmp_a)) begin
            o_hit_a = 1'b1;
            o_fwd_a = i_push_dat;
        end
        if (w_push && (i_push_dst == i_cmp_b)) begin
            o_hit_b = 1'b1;
            o_fwd_b = i_push_dat;
        end
    end
endmodule

// File: rtl/regfile_access_ctrl.sv
// Register-file initiator: operand reads (accept -> op_valid after 3 cycles, held until op_ready)
// and queued writebacks drained one per cycle, with pending writeback data forwarded to reads.
module regfile_access_ctrl
    import regfile_pkg::*;
#(
    parameter int WB_DEPTH = RF_WB_DEPTH,
    parameter int DW       = RF_DW,
    parameter int AW       = RF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_valid,
    output logic          rd_ready,
    input  logic [AW-1:0] rd_src_a,
    input  logic          rd_use_a,
    input  logic [AW-1:0] rd_src_b,
    input  logic          rd_use_b,
    output logic          op_valid,
    input  logic          op_ready,
    output logic [DW-1:0] op_a,
    output logic [DW-1:0] op_b,
    input  logic          wb_valid,
    output logic          wb_ready,
    input  logic [AW-1:0] wb_dst,
    input  logic [DW-1:0] wb_data,
    output logic          wb_empty,
    output logic [AW-1:0] rf_dir_a,
    output logic [AW-1:0] rf_dir_b,
    output logic          rf_re_a_n,
    output logic          rf_re_b_n,
    output logic [AW-1:0] rf_dir_wr,
    output logic [DW-1:0] rf_di,
    output logic          rf_we_n,
    input  logic [DW-1:0] rf_data_a,
    input  logic [DW-1:0] rf_data_b
);
    rd_state_e     r_state;
    logic [AW-1:0] r_rf_dir_a;
    logic [AW-1:0] r_rf_dir_b;
    logic          r_re_a_n;
    logic          r_re_b_n;
    logic          r_use_a;
    logic          r_use_b;
    logic          r_hit_a;
    logic          r_hit_b;
    logic [DW-1:0] r_fwd_a;
    logic [DW-1:0] r_fwd_b;
    logic [DW-1:0] r_op_a;
    logic [DW-1:0] r_op_b;
    logic          r_op_valid;

    logic          w_pop_vld;
    logic [AW-1:0] w_pop_dst;
    logic [DW-1:0] w_pop_dat;
    logic          w_fifo_empty;
    logic          w_hit_a;
    logic          w_hit_b;
    logic [DW-1:0] w_fwd_a;
    logic [DW-1:0] w_fwd_b;

    wb_fifo #(
        .DEPTH  (WB_DEPTH),
        .DATA_W (DW),
        .ADDR_W (AW)
    ) u_wb_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push_vld (wb_valid),
        .i_push_dst (wb_dst),
        .i_push_dat (wb_data),
        .o_push_rdy (wb_ready),
        .o_pop_vld  (w_pop_vld),
        .o_pop_dst  (w_pop_dst),
        .o_pop_dat  (w_pop_dat),
        .o_empty    (w_fifo_empty),
        .i_cmp_a    (r_rf_dir_a),
        .i_cmp_b    (r_rf_dir_b),
        .o_hit_a    (w_hit_a),
        .o_hit_b    (w_hit_b),
        .o_fwd_a    (w_fwd_a),
        .o_fwd_b    (w_fwd_b)
    );

    // The popped entry is committed on this cycle's negedge, ahead of any read on the next posedge.
    assign rf_we_n   = !w_pop_vld;
    assign rf_dir_wr = w_pop_dst;
    assign rf_di     = w_pop_dat;
    assign wb_empty  = w_fifo_empty && rf_we_n;

    assign rd_ready  = (r_state == IDLE);
    assign rf_dir_a  = r_rf_dir_a;
    assign rf_dir_b  = r_rf_dir_b;
    assign rf_re_a_n = r_re_a_n;
    assign rf_re_b_n = r_re_b_n;
    assign op_valid  = r_op_valid;
    assign op_a      = r_op_a;
    assign op_b      = r_op_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rf_dir_a <= '0;
            r_rf_dir_b <= '0;
            r_re_a_n   <= 1'b1;
            r_re_b_n   <= 1'b1;
            r_use_a    <= 1'b0;
            r_use_b    <= 1'b0;
            r_hit_a    <= 1'b0;
            r_hit_b    <= 1'b0;
            r_fwd_a    <= '0;
            r_fwd_b    <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_op_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (rd_valid) begin
                        r_rf_dir_a <= rd_src_a;
                        r_rf_dir_b <= rd_src_b;
                        r_use_a    <= rd_use_a;
                        r_use_b    <= rd_use_b;
                        r_re_a_n   <= !rd_use_a;
                        r_re_b_n   <= !rd_use_b;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_re_a_n <= 1'b1;
                    r_re_b_n <= 1'b1;
                    r_hit_a  <= w_hit_a;
                    r_hit_b  <= w_hit_b;
                    r_fwd_a  <= w_fwd_a;
                    r_fwd_b  <= w_fwd_b;
                    r_state  <= CAPT;
                end
                CAPT: begin
                    r_op_a     <= !r_use_a ? '0 : (r_hit_a ? r_fwd_a : rf_data_a);
                    r_op_b     <= !r_use_b ? '0 : (r_hit_b ? r_fwd_b : rf_data_b);
                    r_op_valid <= 1'b1;
                    r_state    <= HOLD;
                end
                HOLD: begin
                    if (op_ready) begin
                        r_op_valid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
